// File: rtl/mine_field_gen_pkg.sv
// Shared types and constants for the self-populating minesweeper board:
// FSM encoding, LFSR taps and width helpers.
package minefield_pkg;

  localparam int unsigned ADJ_W  = 4;
  localparam int unsigned LFSR_W = 16;
  // x^16 + x^14 + x^13 + x^11 + 1, taps on bits 15, 13, 12, 10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_PICK  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width able to index n values, never narrower than one bit
  function automatic int unsigned cw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mine_field_gen_if.sv
// Control, status and read-port bundle between the game FSM (master)
// and the board generator (slave).
interface mine_field_gen_if
  import minefield_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned HEIGHT    = 8,
  parameter int unsigned NUM_MINES = 10
) ();
  localparam int unsigned XW  = cw(WIDTH);
  localparam int unsigned YW  = cw(HEIGHT);
  localparam int unsigned PCW = cw(NUM_MINES + 1);

  logic             start;
  logic [XW-1:0]    safe_x;
  logic [YW-1:0]    safe_y;
  logic             seed_load;
  logic [15:0]      seed;
  logic             busy;
  logic             done;
  logic [PCW-1:0]   placed_count;
  logic [XW-1:0]    read_x;
  logic [YW-1:0]    read_y;
  logic             read_mine;
  logic [ADJ_W-1:0] read_adj;

  modport master (
    output start, safe_x, safe_y, seed_load, seed, read_x, read_y,
    input  busy, done, placed_count, read_mine, read_adj
  );

  modport slave (
    input  start, safe_x, safe_y, seed_load, seed, read_x, read_y,
    output busy, done, placed_count, read_mine, read_adj
  );
endinterface

// File: rtl/mine_field_gen_lfsr16.sv
// Seedable 16-bit Fibonacci LFSR; a zero seed is replaced by RESET_SEED
// so the register can never lock up at zero.
module lfsr16
  import minefield_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_SEED = 16'hACE1,
  parameter int unsigned       OUT_W      = 6
) (
  input  logic              clk_tb,
  input  logic              reset_tb,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [OUT_W-1:0]  value
);
  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk_tb or negedge reset_tb) begin
    if (!reset_tb)   lfsr_q <= RESET_SEED;
    else if (load)   lfsr_q <= (seed == '0) ? RESET_SEED : seed;
    else if (step)   lfsr_q <= lfsr_next(lfsr_q);
  end

  assign value = lfsr_q[OUT_W-1:0];
endmodule

// File: rtl/mine_field_gen.sv
// Minesweeper board generator: clears the mine and adjacency planes, then
// places NUM_MINES LFSR-chosen mines outside the first-click 3x3 safe zone.
module mine_field_gen
  import minefield_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned HEIGHT    = 8,
  parameter int unsigned NUM_MINES = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic             clk_tb,
  input logic             reset_tb,
  mine_field_gen_if.slave bus
);
  localparam int unsigned XW  = cw(WIDTH);
  localparam int unsigned YW  = cw(HEIGHT);
  localparam int unsigned PCW = cw(NUM_MINES + 1);

  if (int'(NUM_MINES) > int'(WIDTH * HEIGHT) - 9) begin : g_bad_mines
    $error("NUM_MINES exceeds WIDTH*HEIGHT-9");
  end
  if (XW + YW > 16) begin : g_bad_dims
    $error("board coordinates do not fit in the 16-bit LFSR");
  end

  state_e           state_q;
  logic             busy_q, done_q;
  logic [PCW-1:0]   placed_q;
  logic [XW-1:0]    sx_q;
  logic [YW-1:0]    sy_q;
  logic             mine_q [HEIGHT][WIDTH];
  logic [ADJ_W-1:0] adj_q  [HEIGHT][WIDTH];

  logic [XW+YW-1:0] cand_bits;
  logic [XW-1:0]    cx_c;
  logic [YW-1:0]    cy_c;
  int               dx_c, dy_c;
  logic             hit_c, safe_c, accept_c;
  logic             cand_c [HEIGHT][WIDTH];
  logic             nb_c   [HEIGHT][WIDTH];

  lfsr16 #(.RESET_SEED(LFSR_SEED), .OUT_W(XW + YW)) u_lfsr (
    .clk_tb   (clk_tb),
    .reset_tb (reset_tb),
    .load     (state_q == ST_IDLE && bus.seed_load),
    .seed     (bus.seed),
    .step     (state_q == ST_PICK),
    .value    (cand_bits)
  );

  assign cx_c = cand_bits[XW-1:0];
  assign cy_c = cand_bits[XW+YW-1:XW];

  // Candidate decode: target cell, its clipped neighbourhood, and accept decision
  always_comb begin
    hit_c = 1'b0;
    dx_c  = int'(cx_c) - int'(sx_q);
    dy_c  = int'(cy_c) - int'(sy_q);
    for (int y = 0; y < int'(HEIGHT); y++) begin
      for (int x = 0; x < int'(WIDTH); x++) begin
        cand_c[y][x] = (x == int'(cx_c)) && (y == int'(cy_c));
        nb_c[y][x]   = (x - int'(cx_c) >= -1) && (x - int'(cx_c) <= 1) &&
                       (y - int'(cy_c) >= -1) && (y - int'(cy_c) <= 1) &&
                       !cand_c[y][x];
        hit_c        = hit_c | (cand_c[y][x] & mine_q[y][x]);
      end
    end
    safe_c   = (dx_c >= -1) && (dx_c <= 1) && (dy_c >= -1) && (dy_c <= 1);
    // hit_c stays low when the candidate is off-board, so range is checked separately
    accept_c = (state_q == ST_PICK) && (32'(cx_c) < WIDTH) && (32'(cy_c) < HEIGHT) &&
               !hit_c && !safe_c;
  end

  // Combinational read port; out-of-range coordinates match no cell and read 0/0
  always_comb begin
    bus.read_mine = 1'b0;
    bus.read_adj  = '0;
    for (int y = 0; y < int'(HEIGHT); y++) begin
      for (int x = 0; x < int'(WIDTH); x++) begin
        if (x == int'(bus.read_x) && y == int'(bus.read_y)) begin
          bus.read_mine = mine_q[y][x];
          bus.read_adj  = adj_q[y][x];
        end
      end
    end
  end

  always_ff @(posedge clk_tb or negedge reset_tb) begin
    if (!reset_tb) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      placed_q <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      for (int y = 0; y < int'(HEIGHT); y++) begin
        for (int x = 0; x < int'(WIDTH); x++) begin
          mine_q[y][x] <= 1'b0;
          adj_q[y][x]  <= '0;
        end
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            sx_q    <= bus.safe_x;
            sy_q    <= bus.safe_y;
            busy_q  <= 1'b1;
            state_q <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          for (int y = 0; y < int'(HEIGHT); y++) begin
            for (int x = 0; x < int'(WIDTH); x++) begin
              mine_q[y][x] <= 1'b0;
              adj_q[y][x]  <= '0;
            end
          end
          placed_q <= '0;
          state_q  <= ST_PICK;
        end
        ST_PICK: begin
          if (placed_q == PCW'(NUM_MINES)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (accept_c) begin
            // Mine and its up-to-8 neighbours update in a single edge
            for (int y = 0; y < int'(HEIGHT); y++) begin
              for (int x = 0; x < int'(WIDTH); x++) begin
                if (cand_c[y][x]) mine_q[y][x] <= 1'b1;
                if (nb_c[y][x])   adj_q[y][x]  <= adj_q[y][x] + ADJ_W'(1);
              end
            end
            placed_q <= placed_q + PCW'(1);
            if (placed_q == PCW'(NUM_MINES - 1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.placed_count = placed_q;
endmodule
